// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship shot controller: FSM states,
// one-hot ship codes, grid limits, probe offset tables and a helper that keeps
// only the largest ship of a set of one-hot codes.
package battleship_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] PATROL     = 5'b00001;
    localparam logic [4:0] DESTROYER  = 5'b00010;
    localparam logic [4:0] SUBMARINE  = 5'b00100;
    localparam logic [4:0] BATTLESHIP = 5'b01000;
    localparam logic [4:0] CARRIER    = 5'b10000;

    localparam int GRID_MIN         = 1;
    localparam int GRID_MAX_DEFAULT = 10;

    // Probe offsets are 5-bit two's complement so they add straight onto a
    // zero-extended 4-bit coordinate.
    localparam logic [4:0] OFF_M1 = 5'b11111;
    localparam logic [4:0] OFF_Z  = 5'b00000;
    localparam logic [4:0] OFF_P1 = 5'b00001;

    typedef struct packed {
        logic [4:0] dx;
        logic [4:0] dy;
    } offset_t;

    // Small bomb: centre first, then the plus-shaped neighbours.
    // Big bomb: full 3x3 block in row-major order.
    function automatic offset_t probe_offset(input logic big_bomb, input logic [3:0] idx);
        offset_t off;
        off = {OFF_Z, OFF_Z};
        if (big_bomb) begin
            case (idx)
                4'd0:    off = {OFF_M1, OFF_M1};
                4'd1:    off = {OFF_Z,  OFF_M1};
                4'd2:    off = {OFF_P1, OFF_M1};
                4'd3:    off = {OFF_M1, OFF_Z};
                4'd4:    off = {OFF_Z,  OFF_Z};
                4'd5:    off = {OFF_P1, OFF_Z};
                4'd6:    off = {OFF_M1, OFF_P1};
                4'd7:    off = {OFF_Z,  OFF_P1};
                4'd8:    off = {OFF_P1, OFF_P1};
                default: off = {OFF_Z,  OFF_Z};
            endcase
        end else begin
            case (idx)
                4'd0:    off = {OFF_Z,  OFF_Z};
                4'd1:    off = {OFF_Z,  OFF_M1};
                4'd2:    off = {OFF_M1, OFF_Z};
                4'd3:    off = {OFF_P1, OFF_Z};
                4'd4:    off = {OFF_Z,  OFF_P1};
                default: off = {OFF_Z,  OFF_Z};
            endcase
        end
        return off;
    endfunction

    // Keep only the most significant set bit (largest ship).
    function automatic logic [4:0] highest_ship(input logic [4:0] codes);
        logic [4:0] top;
        top = 5'd0;
        for (int i = 0; i < 5; i++) begin
            if (codes[i]) top = 5'd1 << i;
        end
        return top;
    endfunction

endpackage

// File: rtl/battleship_shot_controller_key_edge_sync.sv
// Brings the raw active-low key into the clock domain with two flops and
// emits a single-cycle pulse on its falling edge (key press).
module key_edge_sync (
    input  logic clock,
    input  logic reset_L,
    input  logic key_i,
    output logic press_o
);
    logic sync1_q, sync2_q, prev_q;

    // Synchronizer chain plus one history flop; idle key level is high.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press_o = prev_q & ~sync2_q;

endmodule

// File: rtl/battleship_shot_controller.sv
// Sequences one shot per key press: validates the target, walks the probe
// pattern over the external square checker one square per cycle, then
// publishes hit / near-miss / miss, the largest ship hit, the running count
// of distinct squares hit and the remaining big bombs.
module battleship_shot_controller
    import battleship_pkg::*;
#(
    parameter int BIG_BOMBS = 2,
    parameter int GRID_MAX  = GRID_MAX_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic [3:0] shot_x,
    input  logic [3:0] shot_y,
    input  logic       big,
    input  logic       score_L,
    output logic [3:0] sq_x,
    output logic [3:0] sq_y,
    output logic       sq_valid,
    input  logic [4:0] sq_ship,
    output logic       busy,
    output logic       done,
    output logic       wrong,
    output logic       is_hit,
    output logic       is_near_miss,
    output logic       is_miss,
    output logic [4:0] biggest_ship,
    output logic [4:0] num_hits,
    output logic [1:0] big_left
);
    localparam int         NUM_SQUARES = GRID_MAX * GRID_MAX;
    localparam int         IDX_W       = $clog2(NUM_SQUARES);
    localparam logic [4:0] COORD_MIN   = 5'(GRID_MIN);
    localparam logic [4:0] COORD_MAX   = 5'(GRID_MAX);

    state_t                 state_q, state_d;
    logic [3:0]             x_q, x_d, y_q, y_d;
    logic                   big_q, big_d;
    logic [3:0]             idx_q, idx_d;
    logic                   scored_q, scored_d;       // a scoring probe found a ship
    logic                   neigh_q, neigh_d;         // small bomb: a neighbour found a ship
    logic [4:0]             ships_q, ships_d;         // OR of ship codes from scoring probes
    logic [3:0]             new_hits_q, new_hits_d;   // fresh scoreboard squares this shot
    logic [NUM_SQUARES-1:0] board_q, board_d;
    logic                   wrong_q, wrong_d, hit_q, hit_d, near_q, near_d, miss_q, miss_d;
    logic [4:0]             biggest_q, biggest_d, num_hits_q, num_hits_d;
    logic [1:0]             big_left_q, big_left_d;

    logic             press;
    offset_t          off;
    logic [4:0]       px, py;
    logic             on_grid, probe_valid, probe_ship, probe_scores, probe_new, last_probe;
    logic             reject;
    logic [IDX_W-1:0] sq_idx;
    logic [3:0]       shot_new_hits;
    logic [5:0]       hits_sum;
    logic             final_scored, final_neigh;

    key_edge_sync u_key (
        .clock   (clock),
        .reset_L (reset_L),
        .key_i   (score_L),
        .press_o (press)
    );

    // Current probe square and its classification.
    assign off          = probe_offset(big_q, idx_q);
    assign px           = {1'b0, x_q} + off.dx;
    assign py           = {1'b0, y_q} + off.dy;
    assign on_grid      = (px >= COORD_MIN) && (px <= COORD_MAX) &&
                          (py >= COORD_MIN) && (py <= COORD_MAX);
    assign probe_valid  = (state_q == SCAN) && on_grid;
    assign probe_ship   = probe_valid && (sq_ship != 5'd0);
    // Small bombs only score the centre; neighbours just feed near-miss.
    assign probe_scores = probe_ship && (big_q || (idx_q == 4'd0));
    assign sq_idx       = IDX_W'(py - 5'd1) * IDX_W'(GRID_MAX) + IDX_W'(px - 5'd1);
    assign probe_new    = probe_scores && !board_q[sq_idx];
    assign last_probe   = (idx_q == (big_q ? 4'd8 : 4'd4));

    assign reject = ({1'b0, shot_x} < COORD_MIN) || ({1'b0, shot_x} > COORD_MAX) ||
                    ({1'b0, shot_y} < COORD_MIN) || ({1'b0, shot_y} > COORD_MAX) ||
                    (big && (big_left_q == 2'd0));

    assign shot_new_hits = new_hits_q + {3'b000, probe_new};
    assign hits_sum      = {1'b0, num_hits_q} + {2'b00, shot_new_hits};
    assign final_scored  = scored_q | probe_scores;
    assign final_neigh   = neigh_q | (probe_ship & ~probe_scores);

    // Next-state and datapath updates; everything holds unless changed below.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        big_d      = big_q;
        idx_d      = idx_q;
        scored_d   = scored_q;
        neigh_d    = neigh_q;
        ships_d    = ships_q;
        new_hits_d = new_hits_q;
        board_d    = board_q;
        wrong_d    = wrong_q;
        hit_d      = hit_q;
        near_d     = near_q;
        miss_d     = miss_q;
        biggest_d  = biggest_q;
        num_hits_d = num_hits_q;
        big_left_d = big_left_q;

        case (state_q)
            IDLE: begin
                if (press) begin
                    x_d        = shot_x;
                    y_d        = shot_y;
                    big_d      = big;
                    idx_d      = 4'd0;
                    scored_d   = 1'b0;
                    neigh_d    = 1'b0;
                    ships_d    = 5'd0;
                    new_hits_d = 4'd0;
                    if (reject) begin
                        wrong_d   = 1'b1;
                        hit_d     = 1'b0;
                        near_d    = 1'b0;
                        miss_d    = 1'b0;
                        biggest_d = 5'd0;
                        state_d   = DONE;
                    end else begin
                        if (big) big_left_d = big_left_q - 2'd1;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                scored_d   = final_scored;
                neigh_d    = final_neigh;
                ships_d    = ships_q | (probe_scores ? sq_ship : 5'd0);
                new_hits_d = shot_new_hits;
                if (probe_new) board_d[sq_idx] = 1'b1;
                if (last_probe) begin
                    wrong_d    = 1'b0;
                    hit_d      = final_scored;
                    near_d     = !big_q && !final_scored && final_neigh;
                    miss_d     = !final_scored && (big_q || !final_neigh);
                    biggest_d  = highest_ship(ships_d);
                    num_hits_d = hits_sum[5] ? 5'd31 : hits_sum[4:0];
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, shot context, scoreboard and published results.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= IDLE;
            x_q        <= 4'd0;
            y_q        <= 4'd0;
            big_q      <= 1'b0;
            idx_q      <= 4'd0;
            scored_q   <= 1'b0;
            neigh_q    <= 1'b0;
            ships_q    <= 5'd0;
            new_hits_q <= 4'd0;
            board_q    <= '0;
            wrong_q    <= 1'b0;
            hit_q      <= 1'b0;
            near_q     <= 1'b0;
            miss_q     <= 1'b0;
            biggest_q  <= 5'd0;
            num_hits_q <= 5'd0;
            big_left_q <= 2'(BIG_BOMBS);
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            big_q      <= big_d;
            idx_q      <= idx_d;
            scored_q   <= scored_d;
            neigh_q    <= neigh_d;
            ships_q    <= ships_d;
            new_hits_q <= new_hits_d;
            board_q    <= board_d;
            wrong_q    <= wrong_d;
            hit_q      <= hit_d;
            near_q     <= near_d;
            miss_q     <= miss_d;
            biggest_q  <= biggest_d;
            num_hits_q <= num_hits_d;
            big_left_q <= big_left_d;
        end
    end

    assign sq_x         = (state_q == SCAN) ? px[3:0] : 4'd0;
    assign sq_y         = (state_q == SCAN) ? py[3:0] : 4'd0;
    assign sq_valid     = probe_valid;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign wrong        = wrong_q;
    assign is_hit       = hit_q;
    assign is_near_miss = near_q;
    assign is_miss      = miss_q;
    assign biggest_ship = biggest_q;
    assign num_hits     = num_hits_q;
    assign big_left     = big_left_q;

endmodule

// File: tb/tb_battleship_shot_controller.sv
// Bench for the shot controller: models the square checker, fires directed
// and random shots and compares against a grid-level reference model.
module tb_battleship_shot_controller;
    import battleship_pkg::*;

    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic [3:0] shot_x = 4'd0, shot_y = 4'd0;
    logic       big = 1'b0, score_L = 1'b1;
    logic [3:0] sq_x, sq_y;
    logic       sq_valid, busy, done, wrong, is_hit, is_near_miss, is_miss;
    logic [4:0] sq_ship, biggest_ship, num_hits;
    logic [1:0] big_left;

    typedef struct packed {
        logic       wrong;
        logic       hit;
        logic       near;
        logic       miss;
        logic [4:0] biggest;
        logic [4:0] hits;
        logic [1:0] bl;
    } res_t;

    int passed = 0;
    int total  = 0;

    bit mboard [100];
    int m_hits;
    int m_big_left;

    always #5 clock = ~clock;

    battleship_shot_controller dut (
        .clock        (clock),
        .reset_L      (reset_L),
        .shot_x       (shot_x),
        .shot_y       (shot_y),
        .big          (big),
        .score_L      (score_L),
        .sq_x         (sq_x),
        .sq_y         (sq_y),
        .sq_valid     (sq_valid),
        .sq_ship      (sq_ship),
        .busy         (busy),
        .done         (done),
        .wrong        (wrong),
        .is_hit       (is_hit),
        .is_near_miss (is_near_miss),
        .is_miss      (is_miss),
        .biggest_ship (biggest_ship),
        .num_hits     (num_hits),
        .big_left     (big_left)
    );

    // Fleet layout; off-grid squares return junk that must be ignored.
    function automatic logic [4:0] ship_at(input int x, input int y);
        if (x < 1 || x > 10 || y < 1 || y > 10) return 5'b11111;
        if ((y == 6 && (x == 7 || x == 8)) || (y == 1 && (x == 9 || x == 10))) return PATROL;
        if (x == 2 && y >= 8 && y <= 10) return DESTROYER;
        if (y == 1 && x >= 2 && x <= 4) return SUBMARINE;
        if (y == 2 && x >= 1 && x <= 4) return BATTLESHIP;
        if (y == 3 && x >= 2 && x <= 6) return CARRIER;
        return 5'd0;
    endfunction

    assign sq_ship = ship_at(int'(sq_x), int'(sq_y));

    function automatic res_t observed();
        return {wrong, is_hit, is_near_miss, is_miss, biggest_ship, num_hits, big_left};
    endfunction

    task automatic model_reset();
        foreach (mboard[i]) mboard[i] = 1'b0;
        m_hits     = 0;
        m_big_left = 2;
    endtask

    // Reference: what the shot does to the grid, from the game rules.
    task automatic model_shot(input int x, input int y, input bit b,
                              output res_t r, output int lat, output int nvalid);
        int px, py, hit, nearby, nh;
        logic [4:0] s, ships;
        r = '0; hit = 0; nearby = 0; nh = 0; ships = 5'd0; nvalid = 0;
        if (x < 1 || x > 10 || y < 1 || y > 10 || (b && m_big_left == 0)) begin
            r.wrong = 1'b1;
            lat = 3;
        end else begin
            lat = b ? 12 : 8;
            if (b) m_big_left--;
            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    px = x + dx;
                    py = y + dy;
                    if (!b && dx != 0 && dy != 0) continue;
                    if (px < 1 || px > 10 || py < 1 || py > 10) continue;
                    nvalid++;
                    s = ship_at(px, py);
                    if (s == 5'd0) continue;
                    if (b || (dx == 0 && dy == 0)) begin
                        hit = 1;
                        ships |= s;
                        if (!mboard[(py - 1) * 10 + px - 1]) begin
                            mboard[(py - 1) * 10 + px - 1] = 1'b1;
                            nh++;
                        end
                    end else begin
                        nearby = 1;
                    end
                end
            end
            r.hit  = (hit != 0);
            r.near = !b && hit == 0 && nearby != 0;
            r.miss = !r.hit && !r.near;
            for (int i = 0; i < 5; i++) if (ships[i]) r.biggest = 5'd1 << i;
            m_hits = (m_hits + nh > 31) ? 31 : m_hits + nh;
        end
        r.hits = 5'(m_hits);
        r.bl   = 2'(m_big_left);
    endtask

    task automatic do_reset();
        reset_L = 1'b0; score_L = 1'b1; shot_x = 4'd0; shot_y = 4'd0; big = 1'b0;
        repeat (3) @(negedge clock);
        reset_L = 1'b1;
        repeat (2) @(negedge clock);
        model_reset();
    endtask

    // Press the key and watch until done (bounded). release_at=0 keeps it held.
    task automatic fire_shot(input int x, input int y, input bit b,
                             input int release_at, input int repress_at,
                             output int lat, output int nvalid, output res_t obs,
                             output bit busy_at_done, output bit pulse_one);
        int cyc;
        @(negedge clock);
        shot_x = 4'(x); shot_y = 4'(y); big = b; score_L = 1'b0;
        lat = -1; nvalid = 0; cyc = 0; obs = '0; busy_at_done = 1'b0;
        while (lat < 0 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (sq_valid) nvalid++;
            if (done) begin
                lat = cyc;
                obs = observed();
                busy_at_done = busy;
            end
            if (cyc == release_at) score_L = 1'b1;
            if (repress_at > 0 && cyc == repress_at) score_L = 1'b0;
        end
        @(negedge clock);
        pulse_one = !done;
        if (release_at > 0) begin
            score_L = 1'b1;
            repeat (4) @(negedge clock);
        end
        $display("shot x=%0d y=%0d big=%0d latency=%0d valid_probes=%0d result=%h",
                 x, y, b, lat, nvalid, obs);
    endtask

    // Fire one shot and compare every observable against the model.
    task automatic shot_and_check(input string name, input int x, input int y, input bit b);
        res_t obs, exp_r;
        int lat, nv, elat, env;
        bit bz, p1;
        fire_shot(x, y, b, 3, 0, lat, nv, obs, bz, p1);
        model_shot(x, y, b, exp_r, elat, env);
        total++;
        if (lat !== elat) $display("FAIL %s latency got %0d want %0d", name, lat, elat);
        else passed++;
        total++;
        if (obs !== exp_r) $display("FAIL %s result got %h want %h", name, obs, exp_r);
        else passed++;
        total++;
        if (nv !== env) $display("FAIL %s valid_probes got %0d want %0d", name, nv, env);
        else passed++;
        total++;
        if (!p1 || !bz) $display("FAIL %s done_pulse one_cycle=%0d busy=%0d want 1 1", name, p1, bz);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (observed() !== res_t'({4'b0000, 5'd0, 5'd0, 2'd2}))
            $display("FAIL reset result got %h want %h", observed(), res_t'({4'b0000, 5'd0, 5'd0, 2'd2}));
        else passed++;
        total++;
        if ({done, busy, sq_valid, sq_x, sq_y} !== 11'd0)
            $display("FAIL reset_ctrl got %b want 0", {done, busy, sq_valid, sq_x, sq_y});
        else passed++;
    endtask

    task automatic test_small_hit();
        shot_and_check("small_hit", 2, 9, 1'b0);
        total++;
        if (biggest_ship !== DESTROYER || num_hits !== 5'd1)
            $display("FAIL small_hit_literal got %b/%0d want 00010/1", biggest_ship, num_hits);
        else passed++;
    endtask

    task automatic test_ignore_press();
        res_t obs, exp_r;
        int lat, nv, elat, env, extra;
        bit bz, p1;
        fire_shot(2, 9, 1'b0, 2, 4, lat, nv, obs, bz, p1);
        model_shot(2, 9, 1'b0, exp_r, elat, env);
        total++;
        if (obs !== exp_r || lat !== elat)
            $display("FAIL repeat_shot got %h@%0d want %h@%0d", obs, lat, exp_r, elat);
        else passed++;
        extra = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) extra++;
        end
        total++;
        if (extra !== 0) $display("FAIL ignored_press extra_done got %0d want 0", extra);
        else passed++;
    endtask

    task automatic test_near_miss();
        shot_and_check("near_miss", 6, 6, 1'b0);
    endtask

    task automatic test_big();
        shot_and_check("big_centre", 3, 2, 1'b1);
        total++;
        if (biggest_ship !== CARRIER || num_hits !== 5'd10 || big_left !== 2'd1)
            $display("FAIL big_literal got %b/%0d/%0d want 10000/10/1", biggest_ship, num_hits, big_left);
        else passed++;
        shot_and_check("big_corner", 10, 1, 1'b1);
    endtask

    task automatic test_wrong();
        shot_and_check("wrong_x11", 11, 5, 1'b0);
        shot_and_check("wrong_no_big", 5, 5, 1'b1);
        shot_and_check("wrong_y0", 4, 0, 1'b0);
        shot_and_check("clear_wrong", 5, 5, 1'b0);
    endtask

    task automatic test_held_key();
        res_t obs, exp_r;
        int lat, nv, elat, env, extra;
        bit bz, p1;
        fire_shot(1, 1, 1'b0, 0, 0, lat, nv, obs, bz, p1);
        model_shot(1, 1, 1'b0, exp_r, elat, env);
        total++;
        if (obs !== exp_r || lat !== elat)
            $display("FAIL held_key got %h@%0d want %h@%0d", obs, lat, exp_r, elat);
        else passed++;
        extra = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) extra++;
        end
        total++;
        if (extra !== 0) $display("FAIL held_key extra_done got %0d want 0", extra);
        else passed++;
        score_L = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset_mid_scan();
        int extra;
        @(negedge clock);
        shot_x = 4'd2; shot_y = 4'd9; big = 1'b0; score_L = 1'b0;
        repeat (5) @(negedge clock);
        reset_L = 1'b0;
        #1;
        total++;
        if ({busy, sq_valid, num_hits} !== 7'd0)
            $display("FAIL async_reset got %b want 0", {busy, sq_valid, num_hits});
        else passed++;
        score_L = 1'b1;
        repeat (2) @(negedge clock);
        reset_L = 1'b1;
        model_reset();
        extra = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) extra++;
        end
        total++;
        if (extra !== 0) $display("FAIL reset_abort extra_done got %0d want 0", extra);
        else passed++;
        total++;
        if (observed() !== res_t'({4'b0000, 5'd0, 5'd0, 2'd2}))
            $display("FAIL reset_abort result got %h want %h", observed(), res_t'({4'b0000, 5'd0, 5'd0, 2'd2}));
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            shot_and_check("random", int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                           1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_small_hit();
        test_ignore_press();
        test_near_miss();
        test_big();
        test_wrong();
        test_held_key();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
